// File: rtl/lw_cpu.sv
// lw_cpu: single-cycle 32-bit MIPS-subset core that runs the load-word
// datapath end to end: PC, 32-word instruction ROM, 32x32 register file,
// sign extender, adder ALU and 32-word data memory.
// Optional feature macro: CPU_SW_EN. When defined, sw (opcode 101011)
// stores readDR2 into data memory. When undefined, sw is a NOP and the
// data memory is a read-only initialised array.
// Reset (port "reset") is asynchronous and active-low. It clears the PC and
// the register file. It does not clear data memory.

// ---------------------------------------------------------------------------
// Register file: two combinational read ports, one synchronous write port.
// $0 always reads as zero, and writes to it are dropped.
// ---------------------------------------------------------------------------
module lw_cpu_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data
);

  logic [31:0] Registers [0:31];

  // Register storage: asynchronous clear, write on the rising edge (never to $0)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        Registers[i] <= '0;
      end
    end else if (write_en && (write_addr != 5'd0)) begin
      Registers[write_addr] <= write_data;
    end
  end

  // Read ports: no bypass, so a same-edge write is only seen after the edge
  always_comb begin
    read_data1 = (read_addr1 == 5'd0) ? 32'd0 : Registers[read_addr1];
    read_data2 = (read_addr2 == 5'd0) ? 32'd0 : Registers[read_addr2];
  end

endmodule

// ---------------------------------------------------------------------------
// Core top level
// ---------------------------------------------------------------------------
module lw_cpu (
  input logic clock,
  input logic reset
);

  localparam logic [5:0] OP_LW = 6'b100011;
`ifdef CPU_SW_EN
  localparam logic [5:0] OP_SW = 6'b101011;
`endif

  // Datapath nets, named for hierarchical probing
  logic [31:0] pcAdress;
  logic [31:0] nextPCAdress;
  logic [31:0] instructionWord;
  logic [4:0]  dataRegister1;
  logic [4:0]  wRegister;
  logic [31:0] readDR1;
  logic [31:0] readDR2;
  logic [31:0] extendedWord;
  logic [31:0] ALUSrcA;
  logic [31:0] ALUSrcB;
  logic [31:0] resultALU;
  logic        ALUZero;
  logic [31:0] readDataMem;

  // Program counter state
  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Decode
  logic [5:0]  opcode;
  logic        is_lw;
  logic        reg_we;
  logic [4:0]  mem_idx;
`ifdef CPU_SW_EN
  logic        is_sw;
`endif

  // Instruction ROM contents: the two loads, then zeros.
  // Declaration initialisers give the power-up contents.
  logic [31:0] imem [0:31] = '{
    32'h8C090020, 32'h8C0A0024, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  // Data memory contents: words 8 and 9 hold the load targets.
  logic [31:0] dmem [0:31] = '{
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  assign pcAdress = pc_q;

  // Fetch and next-PC: the ROM index is PC[6:2], so fetch wraps every 128 bytes
  always_comb begin
    instructionWord = imem[pcAdress[6:2]];
    nextPCAdress    = pcAdress + 32'd4;
    pc_d            = nextPCAdress;
  end

  // Decode fields and the sign-extended immediate
  always_comb begin
    opcode        = instructionWord[31:26];
    dataRegister1 = instructionWord[25:21];
    wRegister     = instructionWord[20:16];
    extendedWord  = {{16{instructionWord[15]}}, instructionWord[15:0]};
    is_lw         = (opcode == OP_LW);
    reg_we        = is_lw;
  end

`ifdef CPU_SW_EN
  // Store decode, only present when stores are built in
  always_comb begin
    is_sw = (opcode == OP_SW);
  end
`endif

  lw_cpu_regfile register_file (
    .clock      (clock),
    .reset      (reset),
    .read_addr1 (dataRegister1),
    .read_addr2 (wRegister),
    .read_data1 (readDR1),
    .read_data2 (readDR2),
    .write_en   (reg_we),
    .write_addr (wRegister),
    .write_data (readDataMem)
  );

  // ALU: base + offset address, modulo 2^32
  always_comb begin
    ALUSrcA   = readDR1;
    ALUSrcB   = extendedWord;
    resultALU = ALUSrcA + ALUSrcB;
    ALUZero   = (resultALU == 32'd0);
  end

  // Data memory read: only word bits [6:2] select, so addresses alias
  always_comb begin
    mem_idx     = resultALU[6:2];
    readDataMem = dmem[mem_idx];
  end

  // PC register: back to 0 at once on reset, otherwise advance every edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef CPU_SW_EN
  // Store port: data memory keeps its contents through reset, but no
  // write may happen while reset is held
  always_ff @(posedge clock or negedge reset) begin
    if (reset) begin
      if (is_sw) begin
        dmem[mem_idx] <= readDR2;
      end
    end
  end

  // Bits that exist only for probing or are ignored by the address decode
  logic unused_bits;
  assign unused_bits = ^{pcAdress[31:7], pcAdress[1:0], resultALU[31:7],
                         resultALU[1:0], ALUZero};
`else
  // Bits that exist only for probing or are ignored by the address decode;
  // readDR2 has no consumer when stores are not built in
  logic unused_bits;
  assign unused_bits = ^{pcAdress[31:7], pcAdress[1:0], resultALU[31:7],
                         resultALU[1:0], ALUZero, readDR2};
`endif

endmodule

// File: tb/tb_lw_cpu.sv
// tb_lw_cpu: self-checking bench for lw_cpu. A behavioural model
// (arrays for ROM, RAM and registers, plus a PC) runs one instruction per
// rising edge while reset is high. A compare loop checks every probed
// datapath net and the whole register file on each falling edge. Directed
// phases pin the model to hand-computed values. A randomised program then
// exercises lw, sw (NOP unless CPU_SW_EN) and other opcodes.
module tb_lw_cpu;

  logic clock = 1'b1;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  lw_cpu dut (
    .clock (clock),
    .reset (reset)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_imem [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  // Behavioural model: clears on reset, executes one instruction per edge
  initial begin
    logic [31:0] mi;
    logic [31:0] ma;
    for (int i = 0; i < 32; i++) begin
      m_dmem[i] = 32'd0;
      m_regs[i] = 32'd0;
    end
    m_dmem[8] = 32'hDEADBEEF;
    m_dmem[9] = 32'h12345678;
    m_pc = 32'd0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      end else begin
        mi = m_imem[m_pc[6:2]];
        ma = m_regs[mi[25:21]] + {{16{mi[15]}}, mi[15:0]};
        if (mi[31:26] == 6'b100011) begin
          if (mi[20:16] != 5'd0) m_regs[mi[20:16]] = m_dmem[ma[6:2]];
        end
`ifdef CPU_SW_EN
        else if (mi[31:26] == 6'b101011) begin
          m_dmem[ma[6:2]] = m_regs[mi[20:16]];
        end
`endif
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of the datapath against the model
  task automatic compare_loop();
    logic [31:0] e_instr;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_ext;
    logic [31:0] e_res;
    forever begin
      @(negedge clock);
      if (reset) begin
        e_instr = m_imem[m_pc[6:2]];
        e_a     = m_regs[e_instr[25:21]];
        e_b     = m_regs[e_instr[20:16]];
        e_ext   = {{16{e_instr[15]}}, e_instr[15:0]};
        e_res   = e_a + e_ext;
        check("pcAdress", dut.pcAdress, m_pc);
        check("nextPCAdress", dut.nextPCAdress, m_pc + 32'd4);
        check("instructionWord", dut.instructionWord, e_instr);
        check("dataRegister1", {27'd0, dut.dataRegister1}, {27'd0, e_instr[25:21]});
        check("wRegister", {27'd0, dut.wRegister}, {27'd0, e_instr[20:16]});
        check("readDR1", dut.readDR1, e_a);
        check("readDR2", dut.readDR2, e_b);
        check("extendedWord", dut.extendedWord, e_ext);
        check("ALUSrcA", dut.ALUSrcA, e_a);
        check("ALUSrcB", dut.ALUSrcB, e_ext);
        check("resultALU", dut.resultALU, e_res);
        check("ALUZero", {31'd0, dut.ALUZero}, {31'd0, (e_res == 32'd0)});
        check("readDataMem", dut.readDataMem, m_dmem[e_res[6:2]]);
        for (int i = 0; i < 32; i++) begin
          check($sformatf("Registers[%0d]", i), dut.register_file.Registers[i], m_regs[i]);
        end
        $display("cycle pc=%h instr=%h alu=%h rdata=%h", dut.pcAdress,
                 dut.instructionWord, dut.resultALU, dut.readDataMem);
      end
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 5) op = 6'b100011;
    else if (sel < 8) op = 6'b101011;
    else begin
      op = 6'($urandom_range(0, 63));
      if (op == 6'b100011 || op == 6'b101011) op = 6'b000000;
    end
    rs  = 5'($urandom_range(0, 31));
    rt  = 5'($urandom_range(0, 31));
    imm = 16'($urandom_range(0, 65535));
    return {op, rs, rt, imm};
  endfunction

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 32; i++) m_imem[i] = 32'd0;
    m_imem[0] = 32'h8C090020;
    m_imem[1] = 32'h8C0A0024;
    fork
      compare_loop();
    join_none

    // Phase 1: reset state and the two power-up loads
    #2;
    check("reset pcAdress", dut.pcAdress, 32'd0);
    check("reset Registers[9]", dut.register_file.Registers[9], 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("pre-edge pcAdress", dut.pcAdress, 32'd0);
    check("pre-edge instructionWord", dut.instructionWord, 32'h8C090020);
    check("pc0 resultALU", dut.resultALU, 32'h00000020);
    check("pc0 ALUZero", {31'd0, dut.ALUZero}, 32'd0);
    check("pc0 readDataMem", dut.readDataMem, 32'hDEADBEEF);
    @(posedge clock); #1;
    check("edge1 Registers[9]", dut.register_file.Registers[9], 32'hDEADBEEF);
    check("edge1 pcAdress", dut.pcAdress, 32'd4);
    $display("txn lw $9 -> %h", dut.register_file.Registers[9]);
    @(posedge clock); #1;
    check("edge2 Registers[10]", dut.register_file.Registers[10], 32'h12345678);
    check("edge2 pcAdress", dut.pcAdress, 32'd8);
    $display("txn lw $10 -> %h", dut.register_file.Registers[10]);

    // Phase 2: asynchronous reset between edges
    @(negedge clock); #1 reset = 1'b0;
    #1;
    check("async pcAdress", dut.pcAdress, 32'd0);
    check("async Registers[9]", dut.register_file.Registers[9], 32'd0);
    check("async Registers[10]", dut.register_file.Registers[10], 32'd0);
    check("async dmem[8]", dut.dmem[8], 32'hDEADBEEF);
    $display("txn async reset pc=%h", dut.pcAdress);

    // Phase 3: lw into $0 is dropped
    dut.imem[0] = 32'h8C000020;
    m_imem[0]   = 32'h8C000020;
    @(negedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    check("lw $0 Registers[0]", dut.register_file.Registers[0], 32'd0);
    check("lw $0 pcAdress", dut.pcAdress, 32'd4);
    $display("txn lw $0 -> %h", dut.register_file.Registers[0]);
    @(negedge clock); #1 reset = 1'b0;

    // Phase 4: sw $9,0x28($0) after lw $9
    dut.imem[0] = 32'h8C090020;
    m_imem[0]   = 32'h8C090020;
    dut.imem[1] = 32'hAC090028;
    m_imem[1]   = 32'hAC090028;
    @(negedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    check("sw Registers[9]", dut.register_file.Registers[9], 32'hDEADBEEF);
`ifdef CPU_SW_EN
    check("sw dmem[10]", dut.dmem[10], 32'hDEADBEEF);
`else
    check("sw dmem[10]", dut.dmem[10], 32'h00000000);
`endif
    $display("txn sw $9 -> dmem[10]=%h", dut.dmem[10]);
    @(negedge clock); #1 reset = 1'b0;

    // Phase 5: random program, checked cycle by cycle against the model
    for (int i = 0; i < 32; i++) begin
      w = gen_instr();
      dut.imem[i] = w;
      m_imem[i]   = w;
    end
    @(negedge clock); #1 reset = 1'b1;
    repeat (400) @(posedge clock);
    @(negedge clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lw_cpu.md
# lw_cpu

Single-cycle 32-bit MIPS-subset processor core that executes the load-word (lw) datapath end to end. It contains the PC, instruction ROM, a 32×32 register file, sign extender, ALU and data RAM. It is the top of the simple-implementation datapath; verification observes it through hierarchical probes rather than ports.

## Interface
- Parameters: none.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears PC and register file.
- Required internal nets, 32-bit unless noted, for bench probing:
  - pcAdress, nextPCAdress, instructionWord.
  - dataRegister1 (5-bit rs), wRegister (5-bit rt).
  - readDR1, readDR2, extendedWord.
  - ALUSrcA, ALUSrcB, resultALU, ALUZero (1-bit).
  - readDataMem.
  - Register-file instance register_file, with array Registers[0:31].

## Operation
- Fetch: instructionWord = imem[pcAdress[6:2]]; 32-word ROM, combinational read.
- Decode: dataRegister1 = instr[25:21]; wRegister = instr[20:16]; extendedWord = sign-extend of instr[15:0].
- Register file: two combinational reads (rs → readDR1, rt → readDR2); one synchronous write port. Registers[0] reads 0 always; writes to it are ignored.
- ALU: ALUSrcA = readDR1; ALUSrcB = extendedWord; resultALU = A+B, modulo 2^32; ALUZero = (resultALU == 0).
- Data memory: 32 words; readDataMem = dmem[resultALU[6:2]], combinational. Address bits [1:0] and [31:7] are ignored, so addresses alias.
- lw (opcode 6'b100011): Registers[rt] ← readDataMem at the rising edge.
- Any other opcode (SW handled per Configuration): no register or memory write; PC still advances.
- nextPCAdress = pcAdress + 4, wrapping modulo 2^32. The ROM index therefore wraps every 128 bytes.
- Power-up contents:
  - imem[0] = 0x8C090020 (lw $9,0x20($0)).
  - imem[1] = 0x8C0A0024 (lw $10,0x24($0)).
  - All other imem words = 0.
  - dmem[8] = 0xDEADBEEF; dmem[9] = 0x12345678; all other dmem words = 0.

## Timing
- reset low: pcAdress = 0 and all Registers = 0 immediately, without waiting for a clock edge. Data memory is not cleared.
- reset high: every rising edge commits the current instruction's write and loads pcAdress ← nextPCAdress.
- Latency: one cycle per instruction. The result of the instruction at PC=0 is visible in the register file after the first rising edge following reset release.
- Read-after-write on the same edge: the read port returns the old value until the edge, and the new value after it. There is no internal bypass.
- Reset asserted mid-cycle aborts the pending write; the PC returns to 0.
- Reset released coincident with a clock edge: that edge does not execute. The first execution is on the next edge.

## Configuration
- CPU_SW_EN defined: opcode 6'b101011 (sw) is decoded. On the rising edge, dmem[resultALU[6:2]] ← readDR2; no register write.
- CPU_SW_EN undefined:
  - sw behaves as a NOP.
  - Data memory is a read-only initialized array with no write port.

## Test plan
- Hold reset low for 15 ns, release at a clock low phase -> pcAdress=0 and instructionWord=0x8C090020 before the first edge.
- Same sequence, sample after the first rising edge:
  - Registers[9] = 0xDEADBEEF and pcAdress = 4.
  - While PC=0: resultALU = 0x20 and ALUZero = 0.
- Two rising edges after release -> Registers[10] = 0x12345678 and pcAdress = 8.
- Assert reset low between edges after execution -> pcAdress and Registers[9] read 0 with no clock edge; dmem[8] still holds 0xDEADBEEF.
- lw targeting $0 (imem patched to 0x8C000020) -> Registers[0] stays 0.
- With CPU_SW_EN, run sw $9,0x28($0) after lw $9 -> dmem[10] = 0xDEADBEEF. Without CPU_SW_EN -> dmem[10] = 0.
